// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: fill/drain, chase, ping-pong and blink patterns on a
// WIDTH-bit LED bank, stepped by an internal prescaler with runtime speed/direction.
module led_pattern_seq #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CLK_DIV = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             step_tick
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned PH_W  = $clog2(2 * WIDTH);

  logic [CNT_W-1:0] count_q, count_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic [1:0]       amode_q, amode_d;
  logic             tick_q, tick_d;

  logic [31:0]      period_m1_c;
  logic             step_c;
  logic [PH_W-1:0]  phase_last_c;
  logic [PH_W-1:0]  phase_nxt_c;

  // Pattern as a pure function of mode and phase, so every phase maps to a legal pattern.
  function automatic logic [WIDTH-1:0] pat_f(input logic [1:0] m, input logic [PH_W-1:0] ph);
    logic [WIDTH-1:0] p;
    int k;
    int w;
    int idx;
    k = 32'(ph);
    w = WIDTH;
    idx = (k < w) ? k : (2 * w - 2 - k);
    p = '0;
    for (int i = 0; i < w; i++) begin
      unique case (m)
        2'b00:   p[i] = (k <= w) ? (i < k) : (i >= k - w);
        2'b01:   p[i] = (i == k);
        2'b10:   p[i] = (i == idx);
        default: p[i] = (k == 1);
      endcase
    end
    return p;
  endfunction

  assign period_m1_c = (32'(CLK_DIV) >> speed) - 32'd1;
  // >= rather than == so shortening the period mid-count steps at once instead of overrunning.
  assign step_c      = (32'(count_q) >= period_m1_c);

  always_comb begin
    phase_last_c = PH_W'(1);
    unique case (amode_q)
      2'b00:   phase_last_c = PH_W'(2 * WIDTH - 1);
      2'b01:   phase_last_c = PH_W'(WIDTH - 1);
      2'b10:   phase_last_c = PH_W'(2 * WIDTH - 3);
      default: phase_last_c = PH_W'(1);
    endcase
  end

  assign phase_nxt_c = (phase_q >= phase_last_c) ? '0 : phase_q + PH_W'(1);

  // Mode restart outranks stepping and is honoured even while frozen.
  always_comb begin
    amode_d   = amode_q;
    pattern_d = pattern_q;
    phase_d   = phase_q;
    count_d   = count_q;
    tick_d    = 1'b0;
    if (mode != amode_q) begin
      amode_d   = mode;
      pattern_d = pat_f(mode, '0);
      phase_d   = '0;
      count_d   = '0;
    end else if (en) begin
      if (step_c) begin
        count_d   = '0;
        phase_d   = phase_nxt_c;
        pattern_d = pat_f(amode_q, phase_nxt_c);
        tick_d    = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      phase_q   <= '0;
      pattern_q <= '0;
      amode_q   <= 2'b00;
      tick_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      phase_q   <= phase_d;
      pattern_q <= pattern_d;
      amode_q   <= amode_d;
      tick_q    <= tick_d;
    end
  end

  // Mirror is a plain mux on registered state so direction flips without a restart.
  always_comb begin
    q = pattern_q;
    if (dir) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        q[i] = pattern_q[int'(WIDTH) - 1 - i];
      end
    end
  end

  assign step_tick = tick_q;

endmodule

// File: doc/led_pattern_seq.md
# led_pattern_seq

Parametrised LED pattern sequencer with an internal step-rate prescaler: drives a WIDTH-bit LED bank with one of four runtime-selectable patterns.
- Modes: fill/drain, chase, ping-pong, blink.
- Speed and direction are selectable at runtime.
- Successor to the fixed-rate 8-LED fill/drain block; it absorbs the external tick generator.
- Sits between the board clock and the LED pins.

## Interface
- WIDTH, 8, number of LEDs; legal range ≥ 2.
- CLK_DIV, 25_000_000, base step period in clk cycles at speed = 0; must be ≥ 8.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- en  input  1  run enable; 0 freezes the prescaler and pattern.
- mode  input  2  00 fill/drain, 01 chase, 10 ping-pong, 11 blink.
- speed  input  2  step period = CLK_DIV >> speed cycles (call it P).
- dir  input  1  0 = pattern grows from bit 0; 1 = bit-mirrored (grows from bit WIDTH-1).
- q  output  WIDTH  LED drive, 1 = on.
- step_tick  output  1  one-cycle pulse, high in the first cycle a new pattern is visible.

## Operation
- Internal state:
  - prescaler count: width clog2(CLK_DIV).
  - phase counter: width clog2(2·WIDTH).
  - pattern register: WIDTH bits, LSB-based.
  - active-mode register: 2 bits.
- q = pattern when dir = 0, bit-reversed pattern when dir = 1. This is a pure mux on registered state, so dir changes take effect in the same cycle, with no restart.
- Prescaler:
  - While en = 1, count increments each cycle.
  - When count ≥ P−1: count ← 0 and a step occurs.
  - Using ≥ (not ==) makes a speed change to a shorter period never overrun.
  - en = 0 holds count, phase and pattern unchanged.
- Step behaviour per mode (pattern shown LSB-right, WIDTH = 4):
  - Fill/drain, 2·WIDTH steps, then repeats: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000 …
    - Fill sets the next higher bit.
    - Drain clears the lowest set bit.
  - Chase, WIDTH steps: 0001, 0010, 0100, 1000, 0001 … (single one, rotate left).
  - Ping-pong, 2·WIDTH−2 steps: 0001, 0010, 0100, 1000, 0100, 0010, 0001 … The end bits are lit once per pass, never twice consecutively.
  - Blink, 2 steps: 0000, 1111, 0000 …
- Initial pattern per mode (phase = 0): fill/drain 0, chase bit 0, ping-pong bit 0, blink 0.
- Mode change:
  - Detected when the mode input differs from the active-mode register.
  - On the next edge: active mode ← mode, pattern ← new mode's initial pattern, phase ← 0, count ← 0, step_tick = 0.
  - Restart takes priority over a coincident step, and applies even when en = 0.
- Phase counter wraps at the mode's period length. The pattern is a function of phase and mode; no invalid states are reachable.

## Timing
- Reset values (asynchronous, immediate on reset = 0): count 0, phase 0, pattern 0, active mode 00, q = 0, step_tick = 0.
- After release with en = 1 and no mode change, the first step occurs on the P-th rising edge. The new q is visible after that edge, and step_tick is high for exactly that one cycle.
- Steady state: one step every P cycles. step_tick is never high for two consecutive cycles unless P = 1.
- Mode value ≠ 00 at reset release: the first edge performs the restart; stepping then proceeds P cycles later.
- Reset asserted mid-sequence: all state returns to reset values immediately. The sequence restarts from phase 0 after release.
- en deasserted in the cycle count = P−1: no step. The step occurs on the first enabled edge afterwards.
- Speed change mid-count: if count ≥ new P−1, the step happens on the next enabled edge.

## Test plan
Bench uses WIDTH = 4 and CLK_DIV = 8.
1. Reset:
   - Stimulus: run mode 00 to q = 0111, then pull reset low between edges.
   - Response: q = 0000 and step_tick = 0 immediately.
   - After release with en = 1: first step at edge 8 gives q = 0001.
2. Fill/drain:
   - Stimulus: speed 0, dir 0, en 1, 72 cycles.
   - Response: q = 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001, changing every 8 cycles; step_tick pulses 9 times.
3. Ping-pong with mirror:
   - Stimulus: mode 10, dir 0.
   - Response: q = 0001, 0010, 0100, 1000, 0100, 0010, 0001.
   - Toggling dir to 1 while q = 0010 gives q = 0100 in the same cycle, with no step_tick.
4. Speed:
   - Stimulus: speed 3 (P = 1) in chase mode.
   - Response: q rotates 0001 → 0010 → 0100 → 1000 → 0001 each cycle, with step_tick held high.
   - Then set speed 1 (P = 4) with count = 6: step on the next edge, then every 4 cycles.
5. Mode change and freeze:
   - Stimulus: in mode 00 at q = 0011, switch to mode 01.
   - Response: next edge gives q = 0001 with count = 0; next step after 8 cycles gives 0010.
   - Then en = 0 for 20 cycles: q and count frozen, no step_tick.
